// File: rtl/exu_pkg.sv
// Shared types and constants for the execute stage.
// Contents: ALU operation codes, branch types, operand-select encodings,
// link offset, and the output-slot state encoding.
package exu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      AluAdd  = 4'd0,
      AluSub  = 4'd1,
      AluSll  = 4'd2,
      AluSlt  = 4'd3,
      AluSltu = 4'd4,
      AluXor  = 4'd5,
      AluSrl  = 4'd6,
      AluSra  = 4'd7,
      AluOr   = 4'd8,
      AluAnd  = 4'd9,
      AluEq   = 4'd10
   } alu_op_t;

   typedef enum logic [3:0] {
      BrNone = 4'd0,
      BrJal  = 4'd1,
      BrJalr = 4'd2,
      BrBeq  = 4'd3,
      BrBne  = 4'd4,
      BrBlt  = 4'd5,
      BrBge  = 4'd6,
      BrBltu = 4'd7,
      BrBgeu = 4'd8
   } br_type_t;

   localparam logic ASelRs1 = 1'b0;
   localparam logic ASelPc  = 1'b1;
   localparam logic BSelRs2 = 1'b0;
   localparam logic BSelImm = 1'b1;

   localparam int unsigned LinkOffset = 4;

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/alu.sv
// Integer ALU shared by the execute stage.
// Ports: a_i/b_i operands, op_i operation (alu_op_t encoding), res_o result.
// Compare operations return 0/1 in bit 0.
module alu
   import exu_pkg::*;
#(
   parameter int unsigned Width = XLEN
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [Width-1:0] res_o
);

   localparam int unsigned ShW = $clog2(Width);

   logic [ShW-1:0] shamt;
   assign shamt = b_i[ShW-1:0];

   always_comb begin
      res_o = '0;
      case (alu_op_t'(op_i))
         AluAdd:  res_o = a_i + b_i;
         AluSub:  res_o = a_i - b_i;
         AluSll:  res_o = a_i << shamt;
         AluSlt:  res_o = {{(Width-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         AluSltu: res_o = {{(Width-1){1'b0}}, a_i < b_i};
         AluXor:  res_o = a_i ^ b_i;
         AluSrl:  res_o = a_i >> shamt;
         AluSra:  res_o = $unsigned($signed(a_i) >>> shamt);
         AluOr:   res_o = a_i | b_i;
         AluAnd:  res_o = a_i & b_i;
         AluEq:   res_o = {{(Width-1){1'b0}}, a_i == b_i};
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/exu_bru.sv
// Combinational branch unit: link and target adders, taken decode,
// JALR bit-0 clear and misalignment flag.
// Ports: pc_i, imm_i, alu_res_i, br_type_i in; link_o, is_jump_o,
// redirect_o, target_o, misalign_o out.
module exu_bru
   import exu_pkg::*;
#(
   parameter int unsigned Width = XLEN
) (
   input  logic [Width-1:0] pc_i,
   input  logic [Width-1:0] imm_i,
   input  logic [Width-1:0] alu_res_i,
   input  logic [3:0]       br_type_i,
   output logic [Width-1:0] link_o,
   output logic             is_jump_o,
   output logic             redirect_o,
   output logic [Width-1:0] target_o,
   output logic             misalign_o
);

   logic [Width-1:0] pc_rel;

   assign link_o = pc_i + Width'(LinkOffset);
   // Dedicated adder so the ALU stays free for the compare.
   assign pc_rel = pc_i + imm_i;

   always_comb begin
      is_jump_o  = 1'b0;
      redirect_o = 1'b0;
      target_o   = pc_rel;
      case (br_type_t'(br_type_i))
         BrJal: begin
            is_jump_o  = 1'b1;
            redirect_o = 1'b1;
         end
         BrJalr: begin
            is_jump_o  = 1'b1;
            redirect_o = 1'b1;
            target_o   = {alu_res_i[Width-1:1], 1'b0};
         end
         BrBeq, BrBlt, BrBltu: redirect_o = alu_res_i[0];
         BrBne, BrBge, BrBgeu: redirect_o = ~alu_res_i[0];
         default: ;
      endcase
   end

   assign misalign_o = redirect_o & target_o[1];

endmodule

// File: rtl/exu.sv
// Execute stage: operand select, ALU, branch resolution and a one-entry
// output slot with valid/ready handshakes on both sides.
// Ports: clk_i, rst_n (async, active-low), flush_i; decode side in_*_i with
// in_valid_i/in_ready_o; writeback side out_*_o with out_valid_o/out_ready_i.
module exu
   import exu_pkg::*;
#(
   parameter int unsigned Width = XLEN
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_pc_i,
   input  logic [Width-1:0] in_rs1_i,
   input  logic [Width-1:0] in_rs2_i,
   input  logic [Width-1:0] in_imm_i,
   input  logic             in_a_sel_i,
   input  logic             in_b_sel_i,
   input  logic [3:0]       in_alu_op_i,
   input  logic [3:0]       in_br_type_i,
   input  logic [4:0]       in_rd_i,
   input  logic             in_wen_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_result_o,
   output logic [4:0]       out_rd_o,
   output logic             out_wen_o,
   output logic             out_redirect_o,
   output logic [Width-1:0] out_redirect_pc_o,
   output logic             out_misalign_o
);

   logic [Width-1:0] op_a, op_b, alu_res, link, target;
   logic             is_jump, redirect, misalign, accept;

   slot_state_t      state_q, state_d;
   logic [Width-1:0] result_q, result_d, tgt_q, tgt_d;
   logic [4:0]       rd_q, rd_d;
   logic             wen_q, wen_d, redir_q, redir_d, mis_q, mis_d;

   assign op_a = (in_a_sel_i == ASelPc)  ? in_pc_i  : in_rs1_i;
   assign op_b = (in_b_sel_i == BSelImm) ? in_imm_i : in_rs2_i;

   alu #(.Width(Width)) u_alu (
      .a_i  (op_a),
      .b_i  (op_b),
      .op_i (in_alu_op_i),
      .res_o(alu_res)
   );

   exu_bru #(.Width(Width)) u_bru (
      .pc_i      (in_pc_i),
      .imm_i     (in_imm_i),
      .alu_res_i (alu_res),
      .br_type_i (in_br_type_i),
      .link_o    (link),
      .is_jump_o (is_jump),
      .redirect_o(redirect),
      .target_o  (target),
      .misalign_o(misalign)
   );

   assign in_ready_o = (state_q == StEmpty) | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rd_d     = rd_q;
      wen_d    = wen_q;
      redir_d  = redir_q;
      tgt_d    = tgt_q;
      mis_d    = mis_q;
      if (flush_i) begin
         // Flush wins: slot drops and any same-cycle offer is discarded.
         state_d = StEmpty;
      end else if (accept) begin
         state_d  = StFull;
         result_d = is_jump ? link : alu_res;
         rd_d     = in_rd_i;
         wen_d    = in_wen_i & (in_rd_i != 5'd0);
         redir_d  = redirect;
         tgt_d    = target;
         mis_d    = misalign;
      end else if (out_ready_i) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         result_q <= '0;
         rd_q     <= '0;
         wen_q    <= 1'b0;
         redir_q  <= 1'b0;
         tgt_q    <= '0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         wen_q    <= wen_d;
         redir_q  <= redir_d;
         tgt_q    <= tgt_d;
         mis_q    <= mis_d;
      end
   end

   assign out_valid_o       = (state_q == StFull);
   assign out_result_o      = result_q;
   assign out_rd_o          = rd_q;
   assign out_wen_o         = wen_q;
   assign out_redirect_o    = redir_q;
   assign out_redirect_pc_o = tgt_q;
   assign out_misalign_o    = mis_q;

endmodule

// File: tb/tb_exu.sv
// Directed bench for the execute stage: reset values, ALU and branch cases,
// back-pressure ordering, flush and rd=0 write suppression.
module tb_exu;
   import exu_pkg::*;

   logic        clk, rst_n, flush;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic        in_a_sel, in_b_sel;
   logic [3:0]  in_alu_op, in_br_type;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_redirect_pc;
   logic [4:0]  out_rd;
   logic        out_wen, out_redirect, out_misalign;

   int checks   = 0;
   int failures = 0;

   exu dut (
      .clk_i            (clk),
      .rst_n            (rst_n),
      .flush_i          (flush),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_pc_i          (in_pc),
      .in_rs1_i         (in_rs1),
      .in_rs2_i         (in_rs2),
      .in_imm_i         (in_imm),
      .in_a_sel_i       (in_a_sel),
      .in_b_sel_i       (in_b_sel),
      .in_alu_op_i      (in_alu_op),
      .in_br_type_i     (in_br_type),
      .in_rd_i          (in_rd),
      .in_wen_i         (in_wen),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_result_o     (out_result),
      .out_rd_o         (out_rd),
      .out_wen_o        (out_wen),
      .out_redirect_o   (out_redirect),
      .out_redirect_pc_o(out_redirect_pc),
      .out_misalign_o   (out_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic a_sel, input logic b_sel,
                         input alu_op_t op, input br_type_t br, input logic [4:0] rd,
                         input logic wen);
      in_pc      = pc;
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_imm     = imm;
      in_a_sel   = a_sel;
      in_b_sel   = b_sel;
      in_alu_op  = op;
      in_br_type = br;
      in_rd      = rd;
      in_wen     = wen;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      // ADD 0x7FFFFFFF + 1, held on the input throughout reset
      set_in(32'h0, 32'h7FFF_FFFF, 32'h0, 32'h1, ASelRs1, BSelImm, AluAdd, BrNone, 5'd5, 1'b1);
      step();
      step();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_rd", {27'b0, out_rd}, 32'd0);
      chk("rst_wen", {31'b0, out_wen}, 32'd0);
      chk("rst_redirect", {31'b0, out_redirect}, 32'd0);
      chk("rst_redirect_pc", out_redirect_pc, 32'd0);
      chk("rst_misalign", {31'b0, out_misalign}, 32'd0);
      rst_n = 1'b1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      step();
      chk("add_valid", {31'b0, out_valid}, 32'd1);
      chk("add_result", out_result, 32'h8000_0000);
      chk("add_rd", {27'b0, out_rd}, 32'd5);
      chk("add_wen", {31'b0, out_wen}, 32'd1);
      chk("add_redirect", {31'b0, out_redirect}, 32'd0);

      // BLT -1 < 1 signed: taken to 0x80000010 - 16
      set_in(32'h8000_0010, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, ASelRs1, BSelRs2, AluSlt, BrBlt,
             5'd0, 1'b0);
      step();
      chk("blt_valid", {31'b0, out_valid}, 32'd1);
      chk("blt_redirect", {31'b0, out_redirect}, 32'd1);
      chk("blt_target", out_redirect_pc, 32'h8000_0000);
      chk("blt_misalign", {31'b0, out_misalign}, 32'd0);
      chk("blt_wen", {31'b0, out_wen}, 32'd0);

      // BLTU 0xFFFFFFFF < 1 unsigned: not taken
      set_in(32'h8000_0010, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, ASelRs1, BSelRs2, AluSltu, BrBltu,
             5'd0, 1'b0);
      step();
      chk("bltu_redirect", {31'b0, out_redirect}, 32'd0);
      chk("bltu_result", out_result, 32'd0);

      // BGE with same operands: SLT=1, inverse -> not taken
      set_in(32'h8000_0010, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, ASelRs1, BSelRs2, AluSlt, BrBge,
             5'd0, 1'b0);
      step();
      chk("bge_redirect", {31'b0, out_redirect}, 32'd0);

      // BNE 3 vs 4: EQ=0 -> taken to 0x200+8
      set_in(32'h0000_0200, 32'd3, 32'd4, 32'd8, ASelRs1, BSelRs2, AluEq, BrBne, 5'd0, 1'b0);
      step();
      chk("bne_redirect", {31'b0, out_redirect}, 32'd1);
      chk("bne_target", out_redirect_pc, 32'h0000_0208);

      // JALR to 0x80001003 -> target 0x80001002, bit 1 set -> misaligned
      set_in(32'h8000_0000, 32'h8000_1003, 32'h0, 32'h0, ASelRs1, BSelImm, AluAdd, BrJalr,
             5'd1, 1'b1);
      step();
      chk("jalr_result", out_result, 32'h8000_0004);
      chk("jalr_target", out_redirect_pc, 32'h8000_1002);
      chk("jalr_redirect", {31'b0, out_redirect}, 32'd1);
      chk("jalr_misalign", {31'b0, out_misalign}, 32'd1);
      chk("jalr_wen", {31'b0, out_wen}, 32'd1);

      // JAL pc=0x100 imm=0x20
      set_in(32'h0000_0100, 32'h0, 32'h0, 32'h20, ASelPc, BSelImm, AluAdd, BrJal, 5'd1, 1'b1);
      step();
      chk("jal_result", out_result, 32'h0000_0104);
      chk("jal_target", out_redirect_pc, 32'h0000_0120);
      chk("jal_misalign", {31'b0, out_misalign}, 32'd0);

      // Back-pressure: A=11, B=22, C=33
      set_in(32'h0, 32'd1, 32'h0, 32'd10, ASelRs1, BSelImm, AluAdd, BrNone, 5'd2, 1'b1);
      step();
      chk("bp_a_result", out_result, 32'd11);
      out_ready = 1'b0;
      set_in(32'h0, 32'd2, 32'h0, 32'd20, ASelRs1, BSelImm, AluAdd, BrNone, 5'd3, 1'b1);
      #1;
      chk("bp_in_ready0", {31'b0, in_ready}, 32'd0);
      step();
      chk("bp_hold1_result", out_result, 32'd11);
      chk("bp_hold1_rd", {27'b0, out_rd}, 32'd2);
      chk("bp_hold1_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      chk("bp_hold2_result", out_result, 32'd11);
      chk("bp_hold2_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold2_in_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready1", {31'b0, in_ready}, 32'd1);
      step();
      chk("bp_b_result", out_result, 32'd22);
      chk("bp_b_rd", {27'b0, out_rd}, 32'd3);
      set_in(32'h0, 32'd3, 32'h0, 32'd30, ASelRs1, BSelImm, AluAdd, BrNone, 5'd4, 1'b1);
      step();
      chk("bp_c_result", out_result, 32'd33);
      chk("bp_c_rd", {27'b0, out_rd}, 32'd4);
      in_valid = 1'b0;
      step();
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);

      // rd=0 with wen=1 -> write suppressed
      in_valid = 1'b1;
      set_in(32'h0, 32'd5, 32'h0, 32'd5, ASelRs1, BSelImm, AluAdd, BrNone, 5'd0, 1'b1);
      step();
      chk("rd0_valid", {31'b0, out_valid}, 32'd1);
      chk("rd0_wen", {31'b0, out_wen}, 32'd0);
      chk("rd0_result", out_result, 32'd10);

      // Flush while full and stalled with a new offer pending
      out_ready = 1'b0;
      flush     = 1'b1;
      set_in(32'h0, 32'd100, 32'h0, 32'd1, ASelRs1, BSelImm, AluAdd, BrNone, 5'd7, 1'b1);
      step();
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("flush_never_emitted", {31'b0, out_valid}, 32'd0);
      chk("flush_result_kept", out_result, 32'd10);

      // Asynchronous reset mid-operation
      in_valid = 1'b1;
      set_in(32'h0, 32'd1, 32'h0, 32'd1, ASelRs1, BSelImm, AluAdd, BrNone, 5'd9, 1'b1);
      step();
      chk("pre_arst_valid", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_result", out_result, 32'd0);
      chk("arst_rd", {27'b0, out_rd}, 32'd0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exu.md
# exu

Execute stage of the single-issue RV32I core. Accepts one decoded instruction per handshake from the decode stage, selects ALU operands, runs the ALU, resolves branches and jumps, and registers the result into a one-entry output slot for the memory/writeback stage. It is the only place where control-flow redirects are generated.

## Interface

- WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  core clock. One clock domain; all state on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous kill; drops the output slot and any same-cycle input.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  exu accepts this cycle.
- in_pc  in  WIDTH  instruction address.
- in_rs1, in_rs2  in  WIDTH  register operands.
- in_imm  in  WIDTH  sign-extended immediate.
- in_a_sel  in  1  ALU A: 0 = rs1, 1 = pc.
- in_b_sel  in  1  ALU B: 0 = rs2, 1 = imm.
- in_alu_op  in  alu_op_t  ALU operation.
- in_br_type  in  br_type_t  NONE, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- out_valid  out  1  output slot full.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  ALU result, or pc+4 for JAL/JALR.
- out_rd  out  5  registered in_rd.
- out_wen  out  1  registered in_wen, forced 0 when in_rd = 0.
- out_redirect  out  1  taken branch/jump; meaningful only with out_valid.
- out_redirect_pc  out  WIDTH  redirect target.
- out_misalign  out  1  redirect target bit 1 set (taken only).

## Operation

- A = in_a_sel ? in_pc : in_rs1; B = in_b_sel ? in_imm : in_rs2; drive ALU combinationally.
- Link = in_pc + 4, mod 2^32. Branch target = in_pc + in_imm, mod 2^32 (dedicated adder).
- NONE: result = ALU, no redirect.
- JAL: result = link, redirect to pc+imm. Decoder sends ALU_ADD; ALU output unused.
- JALR: decoder sends ALU_ADD with rs1/imm; target = ALU result with bit 0 cleared; result = link.
- Conditional: decoder sends EQ (BEQ/BNE), SLT (BLT/BGE), SLTU (BLTU/BGEU) on rs1/rs2. Taken = ALU bit 0 for BEQ/BLT/BLTU, its inverse for BNE/BGE/BGEU. Target = pc+imm. Result = ALU output; decoder sets in_wen = 0.
- out_misalign = redirect & target[1]; out_redirect still asserted, downstream traps.
- Unknown br_type behaves as NONE.

## Timing

- Reset: out_valid 0, out_result 0, out_rd 0, out_wen 0, out_redirect 0, out_redirect_pc 0, out_misalign 0.
- Two states in effect: EMPTY (out_valid 0), FULL (out_valid 1).
- in_ready = ~out_valid | out_ready (combinational from out_ready; no skid buffer).
- Accept on in_valid & in_ready: slot loads at that edge; latency 1 cycle; throughput 1/cycle under continuous out_ready.
- FULL with out_ready 0: all out_* hold stable; in_ready 0.
- FULL, out_ready 1, in_valid 0: slot empties.
- FULL, out_ready 1, in_valid 1: slot replaced same edge; out_valid stays 1.
- flush 1: next state EMPTY regardless of in_valid/out_ready; in_ready still follows formula but no load occurs. Flush has priority over all.
- Data outputs are don't-care-stable when EMPTY; they retain last value (no clear).
- Reset mid-operation: slot cleared immediately, no handshake completes.

## Structure

- Shared package (alongside alu_op_t): br_type_t enum, operand-select constants, link offset constant 4.
- Instantiates the existing ALU unchanged.
- One sub-module: exu_bru — combinational branch unit (target adder, link adder, taken decode, JALR bit-0 clear, misalign).
- Output slot and handshake in the top level.

## Test plan

- Reset: hold rst_n 0 with in_valid 1 -> all outputs 0, out_valid 0; release -> first instruction appears one cycle after accept.
- ADD rs1=0x7FFFFFFF, imm=1, b_sel=1, rd=5 -> out_result 0x80000000, out_rd 5, out_wen 1, out_redirect 0.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x80000010, imm=-16 -> out_redirect 1, out_redirect_pc 0x80000000; same with BLTU -> out_redirect 0.
- JALR rs1=0x80001003, imm=0, pc=0x80000000, rd=1 -> out_result 0x80000004, out_redirect_pc 0x80001002, out_misalign 1.
- Back-pressure: 3 back-to-back ADDs, out_ready 0 for 2 cycles after first -> in_ready 0 those cycles, first result held stable, all 3 delivered in order, none lost or duplicated.
- flush in a cycle with out_valid 1, out_ready 0, in_valid 1 -> next cycle out_valid 0, incoming instruction never emitted; rd=0 with in_wen 1 -> out_wen 0.
